// File: rtl/off_mem_responder_if.sv
// Memory-side bus bundle for off_mem_responder: read address/data and
// write address/data/response channels. The responder uses the master
// modport; the memory (or its model) uses the slave modport.
interface off_mem_responder_if #(
  parameter int ADDR_BITS = 32,
  parameter int BEAT_BITS = 32
);
  logic [ADDR_BITS-1:0]   m_araddr;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [BEAT_BITS-1:0]   m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [ADDR_BITS-1:0]   m_awaddr;
  logic                   m_awvalid;
  logic                   m_awready;
  logic [BEAT_BITS-1:0]   m_wdata;
  logic [BEAT_BITS/8-1:0] m_wstrb;
  logic                   m_wvalid;
  logic                   m_wready;
  logic [1:0]             m_bresp;
  logic                   m_bvalid;
  logic                   m_bready;

  modport master (
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  modport slave (
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );
endinterface

// File: rtl/off_mem_responder.sv
// off_mem_responder: moves one DIN_BITS word to/from off-chip memory as
// NB = DIN_BITS/BEAT_BITS single-beat transactions, one address in flight
// at a time. Read and write pointers advance by one word per transaction.
// Build option: define OFF_MEM_WRITE_EN to include the write path; without
// it mode 10 is ignored and all write-channel outputs are tied low.
module off_mem_responder #(
  parameter int                   DIN_BITS  = 128,
  parameter int                   BEAT_BITS = 32,
  parameter int                   ADDR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          axi_sm_mode_i,
  input  logic                init_axi_txn_i,
  input  logic [DIN_BITS-1:0] wr_word_i,
  output logic                dvalid_o,
  output logic [DIN_BITS-1:0] rd_word_o,
  output logic                busy_o,
  output logic                txn_done_o,
  output logic                txn_err_o,
  off_mem_responder_if.master m
);

  localparam int NB = DIN_BITS / BEAT_BITS;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0]        LAST     = CW'(NB - 1);
  localparam logic [ADDR_BITS-1:0] BEAT_INC = ADDR_BITS'(BEAT_BITS / 8);
  localparam logic [ADDR_BITS-1:0] WORD_INC = ADDR_BITS'(DIN_BITS / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_RD_DONE
`ifdef OFF_MEM_WRITE_EN
    , S_WR_ADDR, S_WR_RESP, S_WR_DONE
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic                   init_q;
  logic                   err_q, err_d;
  logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DIN_BITS-1:0]    rd_buf_q, rd_buf_d;
  logic [DIN_BITS-1:0]    rd_word_q, rd_word_d;
  logic                   start_rd;

  assign start_rd = init_axi_txn_i & ~init_q & (axi_sm_mode_i == 2'b01);

`ifdef OFF_MEM_WRITE_EN
  logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DIN_BITS-1:0]    wr_sh_q, wr_sh_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   start_wr;

  assign start_wr = init_axi_txn_i & ~init_q & (axi_sm_mode_i == 2'b10);

  // Write-channel addressing: current beat comes from the bottom of the shifter.
  assign m.m_awaddr = wr_ptr_q + ADDR_BITS'(beat_q) * BEAT_INC;
  assign m.m_wdata  = wr_sh_q[BEAT_BITS-1:0];
  assign m.m_wstrb  = '1;
`else
  logic unused_wr;
  assign unused_wr  = ^{wr_word_i, m.m_awready, m.m_wready, m.m_bresp, m.m_bvalid};
  assign m.m_awaddr = '0;
  assign m.m_wdata  = '0;
  assign m.m_wstrb  = '0;
`endif

  assign m.m_araddr = rd_ptr_q + ADDR_BITS'(beat_q) * BEAT_INC;
  assign busy_o     = (state_q != S_IDLE);
  assign txn_err_o  = err_q;
  assign rd_word_o  = rd_word_q;

  // Next-state and handshake outputs; defaults hold every register.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    err_d       = err_q;
    rd_ptr_d    = rd_ptr_q;
    rd_buf_d    = rd_buf_q;
    rd_word_d   = rd_word_q;
    m.m_arvalid = 1'b0;
    m.m_rready  = 1'b0;
    dvalid_o    = 1'b0;
    txn_done_o  = 1'b0;
`ifdef OFF_MEM_WRITE_EN
    wr_ptr_d    = wr_ptr_q;
    wr_sh_d     = wr_sh_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m.m_awvalid = 1'b0;
    m.m_wvalid  = 1'b0;
    m.m_bready  = 1'b0;
`else
    m.m_awvalid = 1'b0;
    m.m_wvalid  = 1'b0;
    m.m_bready  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_rd) begin
          state_d = S_RD_ADDR;
          beat_d  = '0;
          err_d   = 1'b0;
        end
`ifdef OFF_MEM_WRITE_EN
        else if (start_wr) begin
          state_d   = S_WR_ADDR;
          beat_d    = '0;
          err_d     = 1'b0;
          wr_sh_d   = wr_word_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
`endif
      end
      S_RD_ADDR: begin
        m.m_arvalid = 1'b1;
        if (m.m_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        m.m_rready = 1'b1;
        if (m.m_rvalid) begin
          rd_buf_d[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = m.m_rdata;
          err_d = err_q | (m.m_rresp != 2'b00);
          if (beat_q == LAST) begin
            state_d   = S_RD_DONE;
            rd_word_d = rd_buf_d;
          end else begin
            beat_d  = beat_q + CW'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_RD_DONE: begin
        dvalid_o   = 1'b1;
        txn_done_o = 1'b1;
        rd_ptr_d   = rd_ptr_q + WORD_INC;
        state_d    = S_IDLE;
      end
`ifdef OFF_MEM_WRITE_EN
      S_WR_ADDR: begin
        // AW and W are offered together; each drops after its own handshake.
        m.m_awvalid = ~aw_done_q;
        m.m_wvalid  = ~w_done_q;
        aw_done_d   = aw_done_q | (m.m_awvalid & m.m_awready);
        w_done_d    = w_done_q  | (m.m_wvalid  & m.m_wready);
        if (aw_done_d && w_done_d) begin
          state_d   = S_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: begin
        m.m_bready = 1'b1;
        if (m.m_bvalid) begin
          err_d = err_q | (m.m_bresp != 2'b00);
          if (beat_q == LAST) begin
            state_d = S_WR_DONE;
          end else begin
            beat_d  = beat_q + CW'(1);
            wr_sh_d = wr_sh_q >> BEAT_BITS;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_WR_DONE: begin
        txn_done_o = 1'b1;
        wr_ptr_d   = wr_ptr_q + WORD_INC;
        state_d    = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_ptr_q  <= BASE_ADDR;
      rd_buf_q  <= '0;
      rd_word_q <= '0;
`ifdef OFF_MEM_WRITE_EN
      wr_ptr_q  <= BASE_ADDR;
      wr_sh_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      init_q    <= init_axi_txn_i;
      err_q     <= err_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_buf_q  <= rd_buf_d;
      rd_word_q <= rd_word_d;
`ifdef OFF_MEM_WRITE_EN
      wr_ptr_q  <= wr_ptr_d;
      wr_sh_q   <= wr_sh_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`endif
    end
  end

endmodule

// File: doc/off_mem_responder.md
OFF_MEM_RESPONDER -- requirements
Module: off_mem_responder

Interface
REQ-001 The block SHALL have parameter DIN_BITS, default 128, meaning width of one transferred data word.
REQ-002 The block SHALL have parameter BEAT_BITS, default 32, meaning memory bus beat width; beats per word NB = DIN_BITS/BEAT_BITS = 4.
REQ-003 The block SHALL have parameter ADDR_BITS, default 32, meaning memory byte-address width.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, meaning start byte address of both read and write pointers.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-006 Ports (name direction width meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- axi_sm_mode  in  2  01 = load off-mem data (read), 10 = write off-mem data, others = none
- init_axi_txn  in  1  transaction request; a 0->1 transition starts a transaction
- wr_word  in  DIN_BITS  word to write off-mem, sampled at start
- dvalid  out  1  read word valid, one-cycle pulse
- rd_word  out  DIN_BITS  assembled read word, held until the next read completes
- busy  out  1  transaction in progress
- txn_done  out  1  one-cycle pulse at the end of any transaction
- txn_err  out  1  sticky: a nonzero rresp or bresp was seen in the current or last transaction
- m_araddr/m_arvalid out, m_arready in  ADDR_BITS/1/1  read address channel
- m_rdata in BEAT_BITS, m_rresp in 2, m_rvalid in 1, m_rready out 1  read data channel
- m_awaddr/m_awvalid out, m_awready in  ADDR_BITS/1/1  write address channel
- m_wdata out BEAT_BITS, m_wstrb out BEAT_BITS/8, m_wvalid out, m_wready in  write data channel
- m_bresp in 2, m_bvalid in, m_bready out  write response channel

Function
REQ-007 The block SHALL register init_axi_txn each cycle and start only when it was 0 last cycle, is 1 now, state is IDLE, and axi_sm_mode is 01 (to RD_ADDR) or 10 (to WR_ADDR); otherwise it SHALL ignore the request, including edges that arrive while busy.
REQ-008 At start the block SHALL clear beat_cnt and txn_err and latch wr_word (write) into a shift register.
REQ-009 States SHALL be IDLE, RD_ADDR, RD_DATA, RD_DONE, WR_ADDR, WR_RESP and WR_DONE; busy = (state != IDLE).
REQ-010 The beat address SHALL be ptr + 4*beat_cnt, using rd_ptr in read states and wr_ptr in write states; beat 0 maps to bits [31:0] and beat 3 to bits [127:96].
REQ-011 In RD_ADDR the block SHALL drive m_arvalid=1 with a stable address until m_arready, then go to RD_DATA.
REQ-012 In RD_DATA the block SHALL drive m_rready=1 and, on m_rvalid, capture the beat into slot beat_cnt and OR (m_rresp != 0) into txn_err; it SHALL then go to RD_DONE if beat_cnt == NB-1, else increment beat_cnt and return to RD_ADDR.
REQ-013 In RD_DONE, for exactly one cycle, the block SHALL assert dvalid=1 and txn_done=1 with the assembled word on rd_word, advance rd_ptr by DIN_BITS/8 (16), and go to IDLE.
REQ-014 In WR_ADDR the block SHALL assert m_awvalid and m_wvalid together, drive m_wstrb all ones, and drop each valid independently after its handshake; it SHALL enter WR_RESP once both handshakes have completed, in the same or different cycles.
REQ-015 In WR_RESP the block SHALL drive m_bready=1 and, on m_bvalid, OR (m_bresp != 0) into txn_err; it SHALL go to WR_DONE after beat NB-1, else increment beat_cnt and return to WR_ADDR.
REQ-016 In WR_DONE the block SHALL pulse txn_done for one cycle, advance wr_ptr by 16, and go to IDLE; dvalid SHALL stay 0 on writes.
REQ-017 Pointers SHALL wrap modulo 2^ADDR_BITS without error.
REQ-018 An error response SHALL NOT abort the transaction; all NB beats SHALL complete.
REQ-019 No more than one address request SHALL be outstanding at any time.

Reset
REQ-020 On reset, at any state including mid-transaction, the block SHALL go to IDLE on the next edge with all valid/ready outputs, dvalid, txn_done, busy and txn_err = 0, rd_word = 0, rd_ptr = wr_ptr = BASE_ADDR, beat_cnt = 0 and the edge register = 0.

Configuration
REQ-021 With macro OFF_MEM_WRITE_EN defined, the write path (REQ-014..016) SHALL be present; without it, mode 10 SHALL be ignored like mode 00, the write states and wr_ptr SHALL be absent, m_awvalid/m_wvalid/m_bready SHALL be tied to 0, and m_awaddr/m_wdata/m_wstrb SHALL be tied to 0.

Verification
REQ-022 Read: mode=01, init_axi_txn 0->1, memory returns 0x11111111..0x44444444 at 0x0,4,8,C with arready/rvalid delayed 2 cycles -> one dvalid pulse, rd_word=0x44444444_33333333_22222222_11111111, next read starts at 0x10.
REQ-023 Write (macro on): mode=10, wr_word=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, awready one cycle before wready -> beats 0xAAAAAAAA@0x0 through 0xDDDDDDDD@0xC, txn_done pulse, dvalid=0.
REQ-024 init_axi_txn held high through the read, dropped for one cycle, then raised again -> exactly two reads at 0x0 and 0x10; a level held high with no new edge -> no third read.
REQ-025 Beat 2 returns rresp=2 -> all 4 beats complete, txn_err=1, and txn_err clears at the next start.
REQ-026 Reset asserted during RD_DATA of beat 1 -> IDLE next cycle, all outputs at reset values, next read address 0x0 (BASE_ADDR).
REQ-027 Macro off, mode=10 edge -> busy stays 0 and no channel activity.
